// File: rtl/eth_phy_10g_pcs_pkg.sv
// Shared constants and helpers for the 10GBASE-R receive PCS sync/health core.
package eth_phy_10g_pcs_pkg;

    // Sync header encodings; 2'b00 and 2'b11 are invalid
    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    // Frame sync window and invalid-header tolerance while locked
    localparam int unsigned SH_WINDOW        = 64;
    localparam int unsigned SH_INVALID_LIMIT = 16;

    // BER monitor, error tally and watchdog limits
    localparam int unsigned BER_THRESHOLD  = 15;
    localparam int unsigned ERR_COUNT_MAX  = 127;
    localparam int unsigned WATCHDOG_LIMIT = 8;

    typedef enum logic [0:0] {
        StHunt,
        StLock
    } fs_state_e;

    function automatic logic hdr_is_valid(input logic [1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/eth_phy_10g_pcs_frame_sync.sv
// Block lock acquisition from sync headers, with SERDES bitslip on lock failure.
module eth_phy_10g_pcs_frame_sync
    import eth_phy_10g_pcs_pkg::*;
#(
    parameter int unsigned BITSLIP_HIGH_CYCLES = 1,
    parameter int unsigned BITSLIP_LOW_CYCLES  = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] hdr_i,
    output logic       bitslip_o,
    output logic       block_lock_o,
    output logic       block_lock_next_o
);

    localparam int unsigned SlipMax = (BITSLIP_LOW_CYCLES > BITSLIP_HIGH_CYCLES) ?
                                      BITSLIP_LOW_CYCLES : BITSLIP_HIGH_CYCLES;
    localparam int unsigned SlipW   = $clog2(SlipMax + 1);

    fs_state_e        state_q, state_d;
    logic [5:0]       sh_count_q, sh_count_d;
    logic [3:0]       sh_inv_q, sh_inv_d;
    logic [SlipW-1:0] slip_cnt_q, slip_cnt_d;
    logic             bitslip_q, bitslip_d;

    // Next-state: slip hold-off first, then end of slip pulse, then header evaluation
    always_comb begin
        state_d    = state_q;
        sh_count_d = sh_count_q;
        sh_inv_d   = sh_inv_q;
        slip_cnt_d = slip_cnt_q;
        bitslip_d  = bitslip_q;
        if (slip_cnt_q != '0) begin
            slip_cnt_d = slip_cnt_q - SlipW'(1);
        end else if (bitslip_q) begin
            bitslip_d  = 1'b0;
            slip_cnt_d = SlipW'(BITSLIP_LOW_CYCLES);
        end else if (hdr_is_valid(hdr_i)) begin
            sh_count_d = sh_count_q + 6'd1;
            if (sh_count_q == 6'(SH_WINDOW - 1)) begin
                sh_count_d = '0;
                sh_inv_d   = '0;
                if (sh_inv_q == '0) begin
                    state_d = StLock;
                end
            end
        end else begin
            sh_count_d = sh_count_q + 6'd1;
            sh_inv_d   = sh_inv_q + 4'd1;
            if (state_q != StLock || sh_inv_q == 4'(SH_INVALID_LIMIT - 1)) begin
                sh_count_d = '0;
                sh_inv_d   = '0;
                state_d    = StHunt;
                bitslip_d  = 1'b1;
                slip_cnt_d = SlipW'(BITSLIP_HIGH_CYCLES - 1);
            end else if (sh_count_q == 6'(SH_WINDOW - 1)) begin
                sh_count_d = '0;
                sh_inv_d   = '0;
            end
        end
    end

    // State registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StHunt;
            sh_count_q <= '0;
            sh_inv_q   <= '0;
            slip_cnt_q <= '0;
            bitslip_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_count_q <= sh_count_d;
            sh_inv_q   <= sh_inv_d;
            slip_cnt_q <= slip_cnt_d;
            bitslip_q  <= bitslip_d;
        end
    end

    assign bitslip_o         = bitslip_q;
    assign block_lock_o      = (state_q == StLock);
    // Lets the status logic drop in the same cycle that lock drops
    assign block_lock_next_o = (state_d == StLock);

endmodule

// File: rtl/eth_phy_10g_pcs.sv
// 10GBASE-R receive PCS: frame sync, header BER monitor, link status and SERDES watchdog.
module eth_phy_10g_pcs
    import eth_phy_10g_pcs_pkg::*;
#(
    parameter int unsigned DATA_WIDTH          = 64,
    parameter int unsigned HDR_WIDTH           = 2,
    parameter int unsigned BITSLIP_HIGH_CYCLES = 1,
    parameter int unsigned BITSLIP_LOW_CYCLES  = 8,
    parameter int unsigned COUNT_125US         = 125
) (
    input  logic                  rx_clk,
    input  logic                  rx_rst,
    input  logic [DATA_WIDTH-1:0] serdes_rx_data,
    input  logic [HDR_WIDTH-1:0]  serdes_rx_hdr,
    output logic                  serdes_rx_bitslip,
    output logic                  serdes_rx_reset_req,
    output logic                  rx_block_lock,
    output logic                  rx_high_ber,
    output logic                  rx_status,
    output logic                  rx_bad_block,
    output logic [6:0]            rx_error_count
);

    localparam int unsigned TimerW = $clog2(COUNT_125US + 1);

    // Payload passes straight to the decoder; nothing here looks at it
    logic unused_data;
    assign unused_data = ^serdes_rx_data;

    logic              lock_next;
    logic              hdr_inv;
    logic              expiry;
    logic              link_ok;
    logic              win_all;
    logic [3:0]        ber_next;
    logic [6:0]        tally_next;

    logic [TimerW-1:0] timer_q, timer_d;
    logic [3:0]        ber_q, ber_d;
    logic [6:0]        tally_q, tally_d;
    logic [6:0]        err_q, err_d;
    logic              high_ber_q, high_ber_d;
    logic              status_q, status_d;
    logic              win_ok_q, win_ok_d;
    logic [2:0]        wd_q, wd_d;
    logic              req_q, req_d;
    logic              bad_q, bad_d;

    eth_phy_10g_pcs_frame_sync #(
        .BITSLIP_HIGH_CYCLES (BITSLIP_HIGH_CYCLES),
        .BITSLIP_LOW_CYCLES  (BITSLIP_LOW_CYCLES)
    ) u_frame_sync (
        .clk_i             (rx_clk),
        .rst_i             (rx_rst),
        .hdr_i             (serdes_rx_hdr),
        .bitslip_o         (serdes_rx_bitslip),
        .block_lock_o      (rx_block_lock),
        .block_lock_next_o (lock_next)
    );

    // BER window, error tally, link status and watchdog next-state
    always_comb begin
        hdr_inv    = !hdr_is_valid(serdes_rx_hdr);
        expiry     = (timer_q == '0);
        timer_d    = expiry ? TimerW'(COUNT_125US) : timer_q - TimerW'(1);
        ber_next   = (hdr_inv && ber_q != 4'(BER_THRESHOLD)) ? ber_q + 4'd1 : ber_q;
        tally_next = (hdr_inv && tally_q != 7'(ERR_COUNT_MAX)) ? tally_q + 7'd1 : tally_q;

        ber_d      = ber_next;
        tally_d    = tally_next;
        err_d      = err_q;
        high_ber_d = high_ber_q;
        if (ber_next == 4'(BER_THRESHOLD)) begin
            high_ber_d = 1'b1;
        end
        // The expiring cycle's header still belongs to the closing window
        if (expiry) begin
            ber_d   = '0;
            tally_d = '0;
            err_d   = tally_next;
            if (ber_next != 4'(BER_THRESHOLD)) begin
                high_ber_d = 1'b0;
            end
        end

        link_ok  = lock_next && !high_ber_d;
        win_all  = win_ok_q && link_ok;
        win_ok_d = expiry ? 1'b1 : win_all;
        status_d = status_q;
        if (!link_ok) begin
            status_d = 1'b0;
        end else if (expiry && win_all) begin
            status_d = 1'b1;
        end

        wd_d  = wd_q;
        req_d = 1'b0;
        if (status_d) begin
            wd_d = '0;
        end else if (expiry) begin
            if (wd_q == 3'(WATCHDOG_LIMIT - 1)) begin
                req_d = 1'b1;
                wd_d  = '0;
            end else begin
                wd_d = wd_q + 3'd1;
            end
        end

        bad_d = hdr_inv;
    end

    // Monitor registers
    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            timer_q    <= TimerW'(COUNT_125US);
            ber_q      <= '0;
            tally_q    <= '0;
            err_q      <= '0;
            high_ber_q <= 1'b0;
            status_q   <= 1'b0;
            win_ok_q   <= 1'b1;
            wd_q       <= '0;
            req_q      <= 1'b0;
            bad_q      <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            ber_q      <= ber_d;
            tally_q    <= tally_d;
            err_q      <= err_d;
            high_ber_q <= high_ber_d;
            status_q   <= status_d;
            win_ok_q   <= win_ok_d;
            wd_q       <= wd_d;
            req_q      <= req_d;
            bad_q      <= bad_d;
        end
    end

    assign serdes_rx_reset_req = req_q;
    assign rx_high_ber         = high_ber_q;
    assign rx_status           = status_q;
    assign rx_bad_block        = bad_q;
    assign rx_error_count      = err_q;

endmodule

// File: tb/tb_eth_phy_10g_pcs.sv
// Randomized scoreboard bench for eth_phy_10g_pcs against a header-stream reference model.
module tb_eth_phy_10g_pcs;

    localparam int DW   = 64;
    localparam int HIGH = 1;
    localparam int LOW  = 8;
    // Window longer than 127 cycles so the error tally can saturate
    localparam int CNT  = 149;

    typedef struct packed {
        logic       bitslip;
        logic       req;
        logic       lock;
        logic       high_ber;
        logic       status;
        logic       bad;
        logic [6:0] err;
    } exp_t;

    logic          rx_clk = 1'b0;
    logic          rx_rst = 1'b1;
    logic [DW-1:0] serdes_rx_data = '0;
    logic [1:0]    serdes_rx_hdr = 2'b01;
    logic          serdes_rx_bitslip;
    logic          serdes_rx_reset_req;
    logic          rx_block_lock;
    logic          rx_high_ber;
    logic          rx_status;
    logic          rx_bad_block;
    logic [6:0]    rx_error_count;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    int   req_pulses = 0;

    eth_phy_10g_pcs #(
        .DATA_WIDTH          (DW),
        .HDR_WIDTH           (2),
        .BITSLIP_HIGH_CYCLES (HIGH),
        .BITSLIP_LOW_CYCLES  (LOW),
        .COUNT_125US         (CNT)
    ) dut (
        .rx_clk              (rx_clk),
        .rx_rst              (rx_rst),
        .serdes_rx_data      (serdes_rx_data),
        .serdes_rx_hdr       (serdes_rx_hdr),
        .serdes_rx_bitslip   (serdes_rx_bitslip),
        .serdes_rx_reset_req (serdes_rx_reset_req),
        .rx_block_lock       (rx_block_lock),
        .rx_high_ber         (rx_high_ber),
        .rx_status           (rx_status),
        .rx_bad_block        (rx_bad_block),
        .rx_error_count      (rx_error_count)
    );

    always #5 rx_clk = ~rx_clk;

    // Reference model state, in terms of the link's observable rules
    int m_lock, m_slip_wait, m_slip_out, m_run, m_bad_in_run;
    int m_ber, m_high, m_left, m_tally, m_err, m_status, m_clean_win, m_bad_wins;
    int m_req, m_bad;

    task automatic model_reset();
        m_lock = 0; m_slip_wait = 0; m_slip_out = 0; m_run = 0; m_bad_in_run = 0;
        m_ber = 0; m_high = 0; m_left = CNT; m_tally = 0; m_err = 0;
        m_status = 0; m_clean_win = 1; m_bad_wins = 0; m_req = 0; m_bad = 0;
    endtask

    task automatic model_step(input logic [1:0] h);
        bit inv;
        bit win_end;
        bit ok;
        inv = !(h == 2'b01 || h == 2'b10);
        // Frame sync: headers during a slip and its hold-off are ignored
        if (m_slip_wait > 0) begin
            m_slip_wait--;
        end else if (m_slip_out == 1) begin
            m_slip_out  = 0;
            m_slip_wait = LOW;
        end else begin
            m_run++;
            if (inv) m_bad_in_run++;
            if (inv && (m_lock == 0 || m_bad_in_run == 16)) begin
                m_lock = 0; m_run = 0; m_bad_in_run = 0;
                m_slip_out = 1; m_slip_wait = HIGH - 1;
            end else if (m_run == 64) begin
                if (m_bad_in_run == 0) m_lock = 1;
                m_run = 0; m_bad_in_run = 0;
            end
        end
        // BER window
        if (inv) begin
            m_ber   = (m_ber < 15) ? m_ber + 1 : 15;
            m_tally = (m_tally < 127) ? m_tally + 1 : 127;
        end
        if (m_ber == 15) m_high = 1;
        win_end = (m_left == 0);
        m_left  = win_end ? CNT : m_left - 1;
        if (win_end) begin
            if (m_ber < 15) m_high = 0;
            m_err = m_tally; m_tally = 0; m_ber = 0;
        end
        // Status over a whole window, watchdog over consecutive bad windows
        ok = (m_lock == 1) && (m_high == 0);
        m_clean_win = m_clean_win && ok;
        if (!ok) m_status = 0;
        else if (win_end && m_clean_win) m_status = 1;
        if (win_end) m_clean_win = 1;
        m_req = 0;
        if (m_status == 1) begin
            m_bad_wins = 0;
        end else if (win_end) begin
            m_bad_wins++;
            if (m_bad_wins == 8) begin
                m_req = 1; m_bad_wins = 0;
            end
        end
        m_bad = inv;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.bitslip  = (m_slip_out != 0);
        e.req      = (m_req != 0);
        e.lock     = (m_lock != 0);
        e.high_ber = (m_high != 0);
        e.status   = (m_status != 0);
        e.bad      = (m_bad != 0);
        e.err      = 7'(m_err);
        return e;
    endfunction

    function automatic logic [1:0] good_hdr();
        return ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] bad_hdr();
        return ($urandom_range(0, 1) == 1) ? 2'b00 : 2'b11;
    endfunction

    // One cycle of stimulus; expected response goes to the scoreboard
    task automatic drive(input logic r, input logic [1:0] h);
        @(negedge rx_clk);
        rx_rst         = r;
        serdes_rx_hdr  = h;
        serdes_rx_data = {$urandom, $urandom};
        if (r) model_reset();
        else model_step(h);
        exp_q.push_back(model_out());
    endtask

    task automatic run_good(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, good_hdr());
    endtask

    task automatic run_bad(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, bad_hdr());
    endtask

    task automatic run_random(input int n, input int bad_in_k);
        for (int i = 0; i < n; i++)
            drive(1'b0, ($urandom_range(1, bad_in_k) == 1) ? bad_hdr() : good_hdr());
    endtask

    // Reset asserted between edges must clear the outputs without waiting for a clock
    task automatic async_reset_check();
        exp_t got;
        @(negedge rx_clk);
        rx_rst = 1'b1;
        #1;
        got = '{serdes_rx_bitslip, serdes_rx_reset_req, rx_block_lock, rx_high_ber,
                rx_status, rx_bad_block, rx_error_count};
        tests++;
        if (got != '0) begin
            fails++;
            $display("FAIL async_reset: got %h required 0", got);
        end
        model_reset();
        exp_q.push_back(model_out());
        drive(1'b1, good_hdr());
    endtask

    // Monitor: every cycle the DUT presents registered outputs; compare with the oldest entry
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(posedge rx_clk);
            #1;
            if (serdes_rx_reset_req) req_pulses++;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = '{serdes_rx_bitslip, serdes_rx_reset_req, rx_block_lock, rx_high_ber,
                        rx_status, rx_bad_block, rx_error_count};
                tests++;
                if (got !== e) begin
                    fails++;
                    $display("FAIL outputs t=%0t got slip=%b req=%b lock=%b hber=%b stat=%b bad=%b err=%0d required slip=%b req=%b lock=%b hber=%b stat=%b bad=%b err=%0d",
                             $time, got.bitslip, got.req, got.lock, got.high_ber, got.status,
                             got.bad, got.err, e.bitslip, e.req, e.lock, e.high_ber,
                             e.status, e.bad, e.err);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses_before;
        model_reset();
        repeat (3) drive(1'b1, good_hdr());
        // Clean headers: lock after 64
        run_good(70);
        // Scattered errors within tolerance
        for (int r = 0; r < 4; r++) begin
            run_bad(3);
            run_good(13);
        end
        // 15 in a row: lock held, high BER, then a clean window recovers
        run_bad(15);
        run_good(2 * (CNT + 1) + 10);
        // 16 in a row: lock lost, slip, hold-off, relock
        run_bad(16);
        run_good(100);
        // Alternating while unlocked: repeated slips, never locks
        repeat (2) drive(1'b1, good_hdr());
        for (int i = 0; i < 200; i++) drive(1'b0, (i % 2 == 0) ? good_hdr() : bad_hdr());
        // Mostly clean random traffic long enough for status to come up
        run_random(3 * (CNT + 1), 40);
        // Reset in the middle of a slip
        run_good(80);
        run_bad(16);
        async_reset_check();
        // Invalid headers for 8+ windows: watchdog pulse and saturated tally
        pulses_before = req_pulses;
        run_bad(8 * (CNT + 1) + 5);
        repeat (3) drive(1'b0, bad_hdr());
        tests++;
        if (req_pulses - pulses_before != 1) begin
            fails++;
            $display("FAIL reset_req_count: got %0d required 1", req_pulses - pulses_before);
        end
        // Heavily errored random traffic
        run_random(400, 3);
        run_random(300, 12);
        repeat (3) @(posedge rx_clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
